// File: rtl/mc14433_pkg.sv
// mc14433_pkg: shared types and constants for the MC14433 BCD receiver.
//   rx_state_e - receiver FSM states (strobe index is tracked separately)
//   DSn_IDX    - bit position of each digit strobe in the ds vector
//   bcd_t      - one BCD digit
//   reading_t  - one complete 3 1/2 digit reading
package mc14433_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitDs,
        StSettle,
        StSample,
        StCommit
    } rx_state_e;

    localparam logic [1:0] DS1_IDX = 2'd0;  // most significant (half digit + flags)
    localparam logic [1:0] DS2_IDX = 2'd1;
    localparam logic [1:0] DS3_IDX = 2'd2;
    localparam logic [1:0] DS4_IDX = 2'd3;  // least significant

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic half;
        bcd_t d2;
        bcd_t d3;
        bcd_t d4;
        logic pos;
        logic ovr;
        logic unr;
    } reading_t;

    function automatic logic bcd_ok(input logic [3:0] v);
        return v <= 4'd9;
    endfunction

endpackage

// File: rtl/mc14433_sync.sv
// mc14433_sync: N-stage synchronizer for one asynchronous bit, with a rising-edge
// pulse derived from the synchronized value.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   din  - asynchronous input
//   dout - synchronized level
//   rise - one-cycle pulse on a synchronized 0->1 transition
module mc14433_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
        end
    end

    assign dout = chain_q[STAGES-1];
    assign rise = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mc14433_bcd_rx.sv
// mc14433_bcd_rx: reassembles one 3 1/2 digit reading from the MC14433 multiplexed
// BCD port (digit strobes DS1..DS4, BCD bus Q, EOC).
//   clk, rst              - system clock, synchronous active-high reset
//   eoc_in, ds_in, q_in   - asynchronous chip-side inputs
//   rd_valid              - one-cycle pulse, rd_* updated this cycle
//   rd_half, rd_d2..rd_d4 - half digit and BCD digits, MSD first
//   rd_pos, rd_ovr, rd_unr- polarity and range flags
//   seq_err               - one-cycle pulse on a strobe-sequence violation
//   busy                  - scan in progress
module mc14433_bcd_rx
    import mc14433_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 3,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eoc_in,
    input  logic [3:0] ds_in,
    input  logic [3:0] q_in,
    output logic       rd_valid,
    output logic       rd_half,
    output logic [3:0] rd_d2,
    output logic [3:0] rd_d3,
    output logic [3:0] rd_d4,
    output logic       rd_pos,
    output logic       rd_ovr,
    output logic       rd_unr,
    output logic       seq_err,
    output logic       busy
);

    localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The timeout counter is 10 bits; a larger TIMEOUT clamps to its saturation value.
    localparam logic [9:0]  TmoLimit = (TIMEOUT > 1023) ? 10'h3ff : 10'(TIMEOUT);

    // ---------------------------------------------------------------- synchronizers
    logic       eoc_rise;
    logic       unused_eoc_level;
    logic [3:0] ds_s;
    logic [3:0] ds_rise;
    logic [SYNC_STAGES-1:0][3:0] q_chain_q;
    logic [3:0] q_s;

    mc14433_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync_eoc (
        .clk (clk),
        .rst (rst),
        .din (eoc_in),
        .dout(unused_eoc_level),
        .rise(eoc_rise)
    );

    for (genvar i = 0; i < 4; i++) begin : g_ds_sync
        mc14433_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync_ds (
            .clk (clk),
            .rst (rst),
            .din (ds_in[i]),
            .dout(ds_s[i]),
            .rise(ds_rise[i])
        );
    end

    // Q is only sampled while a strobe has been stable for SETTLE cycles, so a plain
    // vector synchronizer is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_chain_q <= '0;
        end else begin
            q_chain_q[0] <= q_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                q_chain_q[i] <= q_chain_q[i-1];
            end
        end
    end

    assign q_s = q_chain_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------- state
    rx_state_e          state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [9:0]         tmo_q, tmo_d;
    reading_t           shadow_q, shadow_d;
    reading_t           rd_q, rd_d;
    logic               err_q, err_d;

    logic       active;
    logic       multi_hot;
    logic [3:0] cur_mask;
    logic       cur_level;
    logic       cur_rise;
    logic       other_rise;

    always_comb begin
        active     = (state_q == StWaitDs) || (state_q == StSettle) || (state_q == StSample);
        multi_hot  = (ds_s & (ds_s - 4'd1)) != 4'd0;
        cur_mask   = 4'b0001 << idx_q;
        cur_level  = |(ds_s & cur_mask);
        cur_rise   = |(ds_rise & cur_mask);
        other_rise = |(ds_rise & ~cur_mask);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        shadow_d = shadow_q;
        rd_d     = rd_q;
        err_d    = 1'b0;

        // Saturating inter-strobe timer, cleared by any strobe rise.
        if (|ds_rise) begin
            tmo_d = '0;
        end else if (state_q == StWaitDs && tmo_q != 10'h3ff) begin
            tmo_d = tmo_q + 10'd1;
        end else begin
            tmo_d = tmo_q;
        end

        if (active && eoc_rise) begin
            // A fresh conversion restarts the scan; not an error.
            state_d  = StWaitDs;
            idx_d    = DS1_IDX;
            settle_d = '0;
            tmo_d    = '0;
            shadow_d = '0;
        end else if (active && multi_hot) begin
            err_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmo_d = '0;
                    if (eoc_rise) begin
                        state_d  = StWaitDs;
                        idx_d    = DS1_IDX;
                        shadow_d = '0;
                    end else if (ds_rise[DS1_IDX]) begin
                        // Free-running scan recovery: lock onto DS1 without EOC.
                        state_d  = StSettle;
                        idx_d    = DS1_IDX;
                        settle_d = '0;
                        shadow_d = '0;
                    end
                end
                StWaitDs: begin
                    if (cur_rise) begin
                        state_d  = StSettle;
                        settle_d = '0;
                    end else if (other_rise || tmo_q >= TmoLimit) begin
                        err_d = 1'b1;
                    end
                end
                StSettle: begin
                    if (!cur_level) begin
                        err_d = 1'b1;
                    end else if (settle_q == SettleW'(SETTLE - 1)) begin
                        state_d = StSample;
                    end else begin
                        settle_d = settle_q + SettleW'(1);
                    end
                end
                StSample: begin
                    if (idx_q == DS1_IDX) begin
                        shadow_d.half = ~q_s[3];
                        shadow_d.pos  = q_s[2];
                        shadow_d.ovr  = q_s[0] & ~q_s[3];
                        shadow_d.unr  = q_s[0] & q_s[3];
                        state_d       = StWaitDs;
                        idx_d         = DS2_IDX;
                        tmo_d         = '0;
                    end else if (!bcd_ok(q_s)) begin
                        err_d = 1'b1;
                    end else begin
                        unique case (idx_q)
                            DS2_IDX: shadow_d.d2 = q_s;
                            DS3_IDX: shadow_d.d3 = q_s;
                            default: shadow_d.d4 = q_s;
                        endcase
                        if (idx_q == DS4_IDX) begin
                            rd_d    = shadow_d;
                            state_d = StCommit;
                        end else begin
                            state_d = StWaitDs;
                            idx_d   = idx_q + 2'd1;
                            tmo_d   = '0;
                        end
                    end
                end
                StCommit: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (err_d) begin
            state_d  = StIdle;
            idx_d    = DS1_IDX;
            settle_d = '0;
            tmo_d    = '0;
            shadow_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= DS1_IDX;
            settle_q <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    // rd_q is loaded on the edge into StCommit, so data and rd_valid line up.
    assign rd_valid = (state_q == StCommit);
    assign rd_half  = rd_q.half;
    assign rd_d2    = rd_q.d2;
    assign rd_d3    = rd_q.d3;
    assign rd_d4    = rd_q.d4;
    assign rd_pos   = rd_q.pos;
    assign rd_ovr   = rd_q.ovr;
    assign rd_unr   = rd_q.unr;
    assign seq_err  = err_q;
    assign busy     = (state_q != StIdle);

endmodule
